// File: rtl/serial_rx_if.sv
// Core-side handshake of the serial link receiver: word, level-valid/ack, status pulses.
interface serial_rx_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ack;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    modport master (
        output data_out, data_valid, busy, frame_err, overrun,
        input  data_ack
    );

    modport slave (
        input  data_out, data_valid, busy, frame_err, overrun,
        output data_ack
    );
endinterface

// File: rtl/serial_rx.sv
// Receive end of the 2-wire serial link: synchronizes serial_clk/serial_data,
// deserializes one DATA_W-bit word per frame (MSB first), flags timeouts and overruns.
//
// state     | meaning
// WAIT_HIGH | line not yet seen high; falls ignored
// IDLE      | line high; next fall is the frame alert
// RECV      | shifting bits on each fall; timeout armed
module serial_rx #(
    parameter int DATA_W      = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         serial_clk,
    input  logic         serial_data,
    serial_rx_if.master  core
);
    localparam int CW = $clog2(DATA_W);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {WAIT_HIGH, IDLE, RECV} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   sclk_s;
    logic                   sdata_s;
    logic                   sclk_d;
    logic                   fall_q;
    logic                   rise_q;
    logic                   sdata_q;
    logic                   line_high;

    state_t                 state;
    logic [DATA_W-1:0]      shift;
    logic [DATA_W-1:0]      shifted;
    logic [CW-1:0]          bit_cnt;
    logic [TW-1:0]          timer;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign sdata_s = sdata_sync[SYNC_STAGES-1];
    // sclk_d resets low so the reset values of the chain can never count as a real high.
    assign line_high = sclk_d & (&sclk_sync);
    assign shifted   = {shift[DATA_W-2:0], sdata_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= '1;
            sdata_sync <= '0;
            sclk_d     <= 1'b0;
            fall_q     <= 1'b0;
            rise_q     <= 1'b0;
            sdata_q    <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], serial_clk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], serial_data};
            sclk_d     <= sclk_s;
            fall_q     <= sclk_d & ~sclk_s;
            rise_q     <= ~sclk_d & sclk_s;
            sdata_q    <= sdata_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= WAIT_HIGH;
            shift           <= '0;
            bit_cnt         <= '0;
            timer           <= '0;
            core.data_out   <= '0;
            core.data_valid <= 1'b0;
            core.busy       <= 1'b0;
            core.frame_err  <= 1'b0;
            core.overrun    <= 1'b0;
        end else begin
            core.frame_err <= 1'b0;
            core.overrun   <= 1'b0;
            if (core.data_ack && core.data_valid) begin
                core.data_valid <= 1'b0;
            end

            case (state)
                WAIT_HIGH: begin
                    if (line_high) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (fall_q) begin
                        bit_cnt   <= '0;
                        timer     <= '0;
                        core.busy <= 1'b1;
                        state     <= RECV;
                    end
                end
                RECV: begin
                    if (fall_q) begin
                        timer <= '0;
                        shift <= shifted;
                        if (bit_cnt == CW'(DATA_W - 1)) begin
                            // Completion overrides a same-cycle ack: the new word stays valid.
                            core.data_out   <= shifted;
                            core.data_valid <= 1'b1;
                            core.overrun    <= core.data_valid & ~core.data_ack;
                            core.busy       <= 1'b0;
                            bit_cnt         <= '0;
                            state           <= WAIT_HIGH;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (rise_q) begin
                        timer <= '0;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        core.frame_err <= 1'b1;
                        core.busy      <= 1'b0;
                        shift          <= '0;
                        bit_cnt        <= '0;
                        state          <= WAIT_HIGH;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end
endmodule
